// File: rtl/mips_alu_pkg.sv
// rtl/mips_alu_pkg.sv - ALU decode encodings and mul/div sequencer state type
package mips_alu_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [5:0] FUNCT_SLL   = 6'b000000;
  localparam logic [5:0] FUNCT_SRL   = 6'b000010;
  localparam logic [5:0] FUNCT_SRA   = 6'b000011;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_XOR   = 6'b100110;
  localparam logic [5:0] FUNCT_NOR   = 6'b100111;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;
  localparam logic [5:0] FUNCT_SLTU  = 6'b101011;

  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_OR   = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_XOR  = 4'b0011;
  localparam logic [3:0] CTRL_NOR  = 4'b0100;
  localparam logic [3:0] CTRL_SUB  = 4'b0110;
  localparam logic [3:0] CTRL_SLT  = 4'b0111;
  localparam logic [3:0] CTRL_SLL  = 4'b1000;
  localparam logic [3:0] CTRL_SRL  = 4'b1001;
  localparam logic [3:0] CTRL_SRA  = 4'b1010;
  localparam logic [3:0] CTRL_SLTU = 4'b1011;

  typedef enum logic [1:0] {IDLE, RUN, FIX} md_state_t;

endpackage

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative 1-bit/cycle multiply/divide sequencer owning HI/LO
module muldiv_seq
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_rs,
  input  logic [WIDTH-1:0] i_rt,
  input  logic             i_mt_hi,
  input  logic             i_mt_lo,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  md_state_t          r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_a, r_q, r_m, r_hi, r_lo;
  logic               r_is_div, r_neg_q, r_neg_r, r_done;

  // i_op[0] selects the unsigned form, i_op[1] selects divide
  logic               w_signed, w_rs_neg, w_rt_neg;
  logic [WIDTH-1:0]   w_rs_mag, w_rt_mag, w_diff;
  logic [WIDTH:0]     w_sum, w_shift;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;

  assign w_signed   = ~i_op[0];
  assign w_rs_neg   = w_signed & i_rs[WIDTH-1];
  assign w_rt_neg   = w_signed & i_rt[WIDTH-1];
  assign w_rs_mag   = w_rs_neg ? -i_rs : i_rs;
  assign w_rt_mag   = w_rt_neg ? -i_rt : i_rt;

  // Multiply step: conditionally add multiplicand into the upper half, then shift {A,Q} right
  assign w_sum      = {1'b0, r_a} + (r_q[0] ? {1'b0, r_m} : '0);
  // Divide step: shift {R,Q} left, subtract divisor when it fits (restoring)
  assign w_shift    = {r_a, r_q[WIDTH-1]};
  assign w_ge       = (w_shift >= {1'b0, r_m});
  assign w_diff     = w_shift[WIDTH-1:0] - r_m;
  assign w_prod     = {r_a, r_q};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next state: WIDTH iterations in RUN, then one FIX cycle for sign correction
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = RUN;
      RUN:     if (r_cnt == CNT_W'(WIDTH - 1)) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, sign fix and HI/LO writes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_q      <= '0;
      r_m      <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_cnt    <= '0;
            r_a      <= '0;
            r_is_div <= i_op[1];
            // Divide by zero leaves the all-ones quotient uncorrected
            r_neg_q  <= (w_rs_neg ^ w_rt_neg) & ~(i_op[1] & (i_rt == '0));
            r_neg_r  <= w_rs_neg;
            r_q      <= i_op[1] ? w_rs_mag : w_rt_mag;
            r_m      <= i_op[1] ? w_rt_mag : w_rs_mag;
          end else begin
            if (i_mt_hi) r_hi <= i_rs;
            if (i_mt_lo) r_lo <= i_rs;
          end
        end
        RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_is_div) begin
            r_a <= w_ge ? w_diff : w_shift[WIDTH-1:0];
            r_q <= {r_q[WIDTH-2:0], w_ge};
          end else begin
            r_a <= w_sum[WIDTH:1];
            r_q <= {w_sum[0], r_q[WIDTH-1:1]};
          end
        end
        FIX: begin
          r_done <= 1'b1;
          if (r_is_div) begin
            r_lo <= r_neg_q ? -r_q : r_q;
            r_hi <= r_neg_r ? -r_a : r_a;
          end else begin
            {r_hi, r_lo} <= w_prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy = (r_state != IDLE);
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: rtl/alu_ctrl_muldiv.sv
// rtl/alu_ctrl_muldiv.sv - registered ALU control decode with HI/LO and mul/div sequencer
module alu_ctrl_muldiv
  import mips_alu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MD_ENABLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [3:0]       alu_control,
  output logic             illegal,
  output logic [WIDTH-1:0] mf_result,
  output logic             md_busy,
  output logic             md_done,
  output logic             stall
);

  logic [3:0]       r_alu_control;
  logic             r_illegal;
  logic [WIDTH-1:0] r_mf_result;

  logic [3:0]       w_ctrl;
  logic             w_illegal, w_is_md, w_is_mf, w_is_mt, w_hilo, w_accept;
  logic             w_md_busy, w_md_done;
  logic [WIDTH-1:0] w_hi, w_lo;

  // Decode table; HI/LO-class and illegal functs both fall back to ADD
  always_comb begin
    w_ctrl    = CTRL_ADD;
    w_illegal = 1'b0;
    w_is_md   = 1'b0;
    w_is_mf   = 1'b0;
    w_is_mt   = 1'b0;
    case (alu_op)
      ALUOP_ADD: w_ctrl = CTRL_ADD;
      ALUOP_SUB: w_ctrl = CTRL_SUB;
      ALUOP_OR:  w_ctrl = CTRL_OR;
      default: begin
        case (funct)
          FUNCT_ADD, FUNCT_ADDU: w_ctrl = CTRL_ADD;
          FUNCT_SUB, FUNCT_SUBU: w_ctrl = CTRL_SUB;
          FUNCT_AND:  w_ctrl = CTRL_AND;
          FUNCT_OR:   w_ctrl = CTRL_OR;
          FUNCT_XOR:  w_ctrl = CTRL_XOR;
          FUNCT_NOR:  w_ctrl = CTRL_NOR;
          FUNCT_SLT:  w_ctrl = CTRL_SLT;
          FUNCT_SLTU: w_ctrl = CTRL_SLTU;
          FUNCT_SLL:  w_ctrl = CTRL_SLL;
          FUNCT_SRL:  w_ctrl = CTRL_SRL;
          FUNCT_SRA:  w_ctrl = CTRL_SRA;
          FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: begin
            w_is_md   = (MD_ENABLE != 0);
            w_illegal = (MD_ENABLE == 0);
          end
          FUNCT_MFHI, FUNCT_MFLO: begin
            w_is_mf   = (MD_ENABLE != 0);
            w_illegal = (MD_ENABLE == 0);
          end
          FUNCT_MTHI, FUNCT_MTLO: begin
            w_is_mt   = (MD_ENABLE != 0);
            w_illegal = (MD_ENABLE == 0);
          end
          default: w_illegal = 1'b1;
        endcase
      end
    endcase
  end

  assign w_hilo   = w_is_md | w_is_mf | w_is_mt;
  assign stall    = in_valid & w_hilo & w_md_busy;
  assign w_accept = in_valid & ~stall;

  // Decode and mf_result registers update only on accepted instructions
  always_ff @(posedge clk) begin
    if (reset) begin
      r_alu_control <= CTRL_ADD;
      r_illegal     <= 1'b0;
      r_mf_result   <= '0;
    end else if (w_accept) begin
      r_alu_control <= w_ctrl;
      r_illegal     <= w_illegal;
      if (w_is_mf) r_mf_result <= funct[1] ? w_lo : w_hi;
    end
  end

  generate
    if (MD_ENABLE != 0) begin : g_md
      muldiv_seq #(.WIDTH(WIDTH)) u_seq (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_accept & w_is_md),
        .i_op    (funct[1:0]),
        .i_rs    (rs_val),
        .i_rt    (rt_val),
        .i_mt_hi (w_accept & w_is_mt & ~funct[1]),
        .i_mt_lo (w_accept & w_is_mt & funct[1]),
        .o_busy  (w_md_busy),
        .o_done  (w_md_done),
        .o_hi    (w_hi),
        .o_lo    (w_lo)
      );
    end else begin : g_no_md
      assign w_md_busy = 1'b0;
      assign w_md_done = 1'b0;
      assign w_hi      = '0;
      assign w_lo      = '0;
    end
  endgenerate

  assign alu_control = r_alu_control;
  assign illegal     = r_illegal;
  assign mf_result   = r_mf_result;
  assign md_busy     = w_md_busy;
  assign md_done     = w_md_done;

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// tb/tb_alu_ctrl_muldiv.sv - scoreboard bench for alu_ctrl_muldiv
module tb_alu_ctrl_muldiv;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, in_valid;
  logic [1:0]   alu_op;
  logic [5:0]   funct;
  logic [W-1:0] rs_val, rt_val;
  logic [3:0]   alu_control;
  logic         illegal;
  logic [W-1:0] mf_result;
  logic         md_busy, md_done, stall;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [W-1:0] val_q[$];
  logic [4:0]   dec_q[$];

  always #5 clk = ~clk;

  alu_ctrl_muldiv #(.WIDTH(W), .MD_ENABLE(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .alu_op      (alu_op),
    .funct       (funct),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .alu_control (alu_control),
    .illegal     (illegal),
    .mf_result   (mf_result),
    .md_busy     (md_busy),
    .md_done     (md_done),
    .stall       (stall)
  );

  task automatic drive(input logic [1:0] op, input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b);
    alu_op = op; funct = fn; rs_val = a; rt_val = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 100;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (md_done) begin cyc = i; break; end
    end
  endtask

  task automatic hold_until_accept(input logic [5:0] fn, input logic [W-1:0] a, output int cnt, output int dones);
    cnt = 0; dones = 0;
    alu_op = 2'b10; funct = fn; rs_val = a; rt_val = '0; in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (md_done) dones++;
      if (!stall) break;
      cnt++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  function automatic logic [63:0] md_model(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic [63:0] p;
    sa = a; sb = b;
    case (fn[1:0])
      2'b00:   p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      2'b01:   p = {32'b0, a} * {32'b0, b};
      2'b10:   p = (b == 0) ? {a, 32'hFFFFFFFF} : {32'(sa % sb), 32'(sa / sb)};
      default: p = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
    endcase
    return p;
  endfunction

  task automatic test_reset;
    logic [W-1:0] e;
    logic [4:0] d;
    reset = 1'b1; in_valid = 1'b0; alu_op = 2'b00; funct = '0; rs_val = '0; rt_val = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    n_cmp++; if (alu_control !== 4'b0010) begin n_fail++; $display("FAIL reset_alu_control got=%b exp=0010", alu_control); end
    n_cmp++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got=%b exp=0", illegal); end
    n_cmp++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL reset_md_busy got=%b exp=0", md_busy); end
    n_cmp++; if (md_done !== 1'b0) begin n_fail++; $display("FAIL reset_md_done got=%b exp=0", md_done); end
    n_cmp++; if (mf_result !== '0) begin n_fail++; $display("FAIL reset_mf_result got=%h exp=0", mf_result); end
    val_q.push_back('0);
    drive(2'b10, 6'b010000, '0, '0);
    e = val_q.pop_front();
    n_cmp++; if (mf_result !== e) begin n_fail++; $display("FAIL reset_hi got=%h exp=%h", mf_result, e); end
    val_q.push_back('0);
    drive(2'b10, 6'b010010, '0, '0);
    e = val_q.pop_front();
    n_cmp++; if (mf_result !== e) begin n_fail++; $display("FAIL reset_lo got=%h exp=%h", mf_result, e); end
    dec_q.push_back({4'b0110, 1'b0});
    drive(2'b01, 6'b000000, '0, '0);
    d = dec_q.pop_front();
    n_cmp++; if ({alu_control, illegal} !== d) begin n_fail++; $display("FAIL reset_then_sub got=%b exp=%b", {alu_control, illegal}, d); end
  endtask

  task automatic test_decode;
    logic [12:0] tbl [19] = '{
      {2'b00, 6'b100010, 4'b0010, 1'b0},
      {2'b01, 6'b000000, 4'b0110, 1'b0},
      {2'b10, 6'b000011, 4'b1010, 1'b0},
      {2'b10, 6'b111111, 4'b0010, 1'b1},
      {2'b10, 6'b100100, 4'b0000, 1'b0},
      {2'b10, 6'b101011, 4'b1011, 1'b0},
      {2'b10, 6'b100111, 4'b0100, 1'b0},
      {2'b10, 6'b100000, 4'b0010, 1'b0},
      {2'b10, 6'b100001, 4'b0010, 1'b0},
      {2'b10, 6'b100010, 4'b0110, 1'b0},
      {2'b10, 6'b100011, 4'b0110, 1'b0},
      {2'b10, 6'b100101, 4'b0001, 1'b0},
      {2'b10, 6'b100110, 4'b0011, 1'b0},
      {2'b10, 6'b101010, 4'b0111, 1'b0},
      {2'b10, 6'b000000, 4'b1000, 1'b0},
      {2'b10, 6'b000010, 4'b1001, 1'b0},
      {2'b10, 6'b000001, 4'b0010, 1'b1},
      {2'b10, 6'b010100, 4'b0010, 1'b1},
      {2'b11, 6'b000000, 4'b0001, 1'b0}
    };
    logic [12:0] ent;
    logic [4:0] d;
    for (int i = 0; i < 19; i++) begin
      ent = tbl[i];
      dec_q.push_back(ent[4:0]);
      drive(ent[12:11], ent[10:5], '0, '0);
      d = dec_q.pop_front();
      n_cmp++; if ({alu_control, illegal} !== d) begin n_fail++; $display("FAIL decode_%0d got=%b exp=%b", i, {alu_control, illegal}, d); end
    end
    alu_op = 2'b01; funct = 6'b111111; in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if ({alu_control, illegal} !== 5'b00010) begin n_fail++; $display("FAIL decode_hold got=%b exp=00010", {alu_control, illegal}); end
  endtask

  task automatic test_muldiv;
    logic [133:0] vec [7] = '{
      {6'b011000, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB},
      {6'b011001, 32'hFFFFFFFD, 32'h00000007, 32'h00000006, 32'hFFFFFFEB},
      {6'b011010, 32'hFFFFFF9C, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFF2},
      {6'b011011, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF},
      {6'b011010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000},
      {6'b011010, 32'hFFFFFF9C, 32'h00000000, 32'hFFFFFF9C, 32'hFFFFFFFF},
      {6'b011011, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF}
    };
    logic [133:0] v;
    logic [5:0] fn;
    logic [W-1:0] a, b, e;
    logic [63:0] m;
    int cyc;
    for (int i = 0; i < 13; i++) begin
      if (i < 7) begin
        v = vec[i];
        fn = v[133:128]; a = v[127:96]; b = v[95:64];
        val_q.push_back(v[63:32]);
        val_q.push_back(v[31:0]);
      end else begin
        fn = {4'b0110, 2'($urandom_range(0, 3))};
        a = $urandom; b = $urandom;
        if (i == 8) b = 32'($urandom_range(1, 255));
        if (b == '0) b = 32'd1;
        if (a == 32'h80000000) a = 32'd1;
        m = md_model(fn, a, b);
        val_q.push_back(m[63:32]);
        val_q.push_back(m[31:0]);
      end
      drive(2'b10, fn, a, b);
      n_cmp++; if (md_busy !== 1'b1) begin n_fail++; $display("FAIL md_busy_after_accept_%0d got=%b exp=1", i, md_busy); end
      n_cmp++; if (alu_control !== 4'b0010) begin n_fail++; $display("FAIL md_ctrl_add_%0d got=%b exp=0010", i, alu_control); end
      wait_done(cyc);
      n_cmp++; if (cyc !== 33) begin n_fail++; $display("FAIL md_latency_%0d got=%0d exp=33", i, cyc); end
      n_cmp++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL md_busy_at_done_%0d got=%b exp=0", i, md_busy); end
      drive(2'b10, 6'b010000, '0, '0);
      e = val_q.pop_front();
      n_cmp++; if (mf_result !== e) begin n_fail++; $display("FAIL md_hi_%0d fn=%b a=%h b=%h got=%h exp=%h", i, fn, a, b, mf_result, e); end
      n_cmp++; if (md_done !== 1'b0) begin n_fail++; $display("FAIL md_done_width_%0d got=%b exp=0", i, md_done); end
      drive(2'b10, 6'b010010, '0, '0);
      e = val_q.pop_front();
      n_cmp++; if (mf_result !== e) begin n_fail++; $display("FAIL md_lo_%0d fn=%b a=%h b=%h got=%h exp=%h", i, fn, a, b, mf_result, e); end
    end
  endtask

  task automatic test_stall_mflo;
    int cnt, dones;
    logic [W-1:0] e;
    drive(2'b10, 6'b010011, '0, '0);
    val_q.push_back(32'hFFFFFFEB);
    drive(2'b10, 6'b011000, 32'hFFFFFFFD, 32'h7);
    hold_until_accept(6'b010010, '0, cnt, dones);
    n_cmp++; if (cnt !== 33) begin n_fail++; $display("FAIL stall_mflo_cycles got=%0d exp=33", cnt); end
    n_cmp++; if (dones !== 1) begin n_fail++; $display("FAIL stall_mflo_done_pulses got=%0d exp=1", dones); end
    e = val_q.pop_front();
    n_cmp++; if (mf_result !== e) begin n_fail++; $display("FAIL stall_mflo_value got=%h exp=%h", mf_result, e); end
  endtask

  task automatic test_back_to_back;
    int cnt, dones;
    logic [W-1:0] e;
    drive(2'b10, 6'b011001, 32'd5, 32'd6);
    alu_op = 2'b10; funct = 6'b100010; in_valid = 1'b1;
    @(negedge clk);
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_sub_no_stall got=%b exp=0", stall); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++; if (alu_control !== 4'b0110) begin n_fail++; $display("FAIL b2b_sub_ctrl got=%b exp=0110", alu_control); end
    val_q.push_back(32'hCAFEF00D);
    val_q.push_back(32'h0BADBEEF);
    hold_until_accept(6'b010001, 32'hCAFEF00D, cnt, dones);
    n_cmp++; if (cnt !== 32) begin n_fail++; $display("FAIL b2b_mthi_stall_cycles got=%0d exp=32", cnt); end
    drive(2'b10, 6'b010011, 32'h0BADBEEF, '0);
    drive(2'b10, 6'b010000, '0, '0);
    e = val_q.pop_front();
    n_cmp++; if (mf_result !== e) begin n_fail++; $display("FAIL b2b_mthi got=%h exp=%h", mf_result, e); end
    drive(2'b10, 6'b010010, '0, '0);
    e = val_q.pop_front();
    n_cmp++; if (mf_result !== e) begin n_fail++; $display("FAIL b2b_mtlo got=%h exp=%h", mf_result, e); end
  endtask

  task automatic test_reset_abort;
    int dones, cyc;
    logic [W-1:0] e;
    drive(2'b10, 6'b010001, 32'hA5A5A5A5, '0);
    drive(2'b10, 6'b010011, 32'h5A5A5A5A, '0);
    val_q.push_back(32'hA5A5A5A5);
    drive(2'b10, 6'b010000, '0, '0);
    e = val_q.pop_front();
    n_cmp++; if (mf_result !== e) begin n_fail++; $display("FAIL abort_pre_hi got=%h exp=%h", mf_result, e); end
    drive(2'b10, 6'b011000, 32'd1234, 32'd5678);
    drive(2'b10, 6'b100010, '0, '0);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_cmp++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL abort_md_busy got=%b exp=0", md_busy); end
    n_cmp++; if (md_done !== 1'b0) begin n_fail++; $display("FAIL abort_md_done got=%b exp=0", md_done); end
    n_cmp++; if (alu_control !== 4'b0010) begin n_fail++; $display("FAIL abort_alu_control got=%b exp=0010", alu_control); end
    n_cmp++; if (mf_result !== '0) begin n_fail++; $display("FAIL abort_mf_result got=%h exp=0", mf_result); end
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (md_done) dones++;
    end
    n_cmp++; if (dones !== 0) begin n_fail++; $display("FAIL abort_no_done got=%0d exp=0", dones); end
    val_q.push_back('0);
    val_q.push_back('0);
    drive(2'b10, 6'b010000, '0, '0);
    e = val_q.pop_front();
    n_cmp++; if (mf_result !== e) begin n_fail++; $display("FAIL abort_hi_cleared got=%h exp=%h", mf_result, e); end
    drive(2'b10, 6'b010010, '0, '0);
    e = val_q.pop_front();
    n_cmp++; if (mf_result !== e) begin n_fail++; $display("FAIL abort_lo_cleared got=%h exp=%h", mf_result, e); end
    val_q.push_back(32'h00000001);
    val_q.push_back(32'h00000000);
    drive(2'b10, 6'b011001, 32'h00010000, 32'h00010000);
    wait_done(cyc);
    n_cmp++; if (cyc !== 33) begin n_fail++; $display("FAIL abort_fresh_latency got=%0d exp=33", cyc); end
    drive(2'b10, 6'b010000, '0, '0);
    e = val_q.pop_front();
    n_cmp++; if (mf_result !== e) begin n_fail++; $display("FAIL abort_fresh_hi got=%h exp=%h", mf_result, e); end
    drive(2'b10, 6'b010010, '0, '0);
    e = val_q.pop_front();
    n_cmp++; if (mf_result !== e) begin n_fail++; $display("FAIL abort_fresh_lo got=%h exp=%h", mf_result, e); end
  endtask

  initial begin
    test_reset;
    test_decode;
    test_muldiv;
    test_stall_mflo;
    test_back_to_back;
    test_reset_abort;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
